// File: rtl/mult_div_unit.sv
// Iterative MIPS-32 multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO registers.
// Define MDU_DIV_EN to build the divider and divide-by-zero path; undefined gives a multiply-only unit.
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {IDLE, RUN, DZ} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opA_q, opA_d;
  logic              negRes_q, negRes_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic              isSigned;
  logic              startOk;
  logic [XLEN-1:0]   absRs, absRt;
  logic [XLEN-1:0]   mulAddend;
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulNext, mulFinal;

  assign isSigned = ~op[0];
  assign absRs    = (isSigned && rs_data[XLEN-1]) ? -rs_data : rs_data;
  assign absRt    = (isSigned && rt_data[XLEN-1]) ? -rt_data : rt_data;

  // Multiplier bits shift out of the low half while product bits shift in from the top.
  assign mulAddend = acc_q[0] ? opA_q : '0;
  assign mulSum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mulAddend};
  assign mulNext   = {mulSum, acc_q[XLEN-1:1]};
  assign mulFinal  = negRes_q ? -mulNext : mulNext;

`ifdef MDU_DIV_EN
  logic              isDiv_q, isDiv_d;
  logic              negRem_q, negRem_d;
  logic              dz_q, dz_d;
  logic [XLEN:0]     divShift;
  logic [XLEN-1:0]   divDiff, divRem, quotFinal, remFinal;
  logic              divGe;
  logic [2*XLEN-1:0] divNext;

  // Restoring step: remainder in the high half, dividend/quotient bits in the low half.
  assign divShift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign divGe     = divShift >= {1'b0, opA_q};
  assign divDiff   = divShift[XLEN-1:0] - opA_q;
  assign divRem    = divGe ? divDiff : divShift[XLEN-1:0];
  assign divNext   = {divRem, acc_q[XLEN-2:0], divGe};
  assign quotFinal = negRes_q ? -divNext[XLEN-1:0] : divNext[XLEN-1:0];
  assign remFinal  = negRem_q ? -divNext[2*XLEN-1:XLEN] : divNext[2*XLEN-1:XLEN];
  assign startOk   = start;
`else
  assign startOk   = start && !op[1];
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opA_d    = opA_q;
    negRes_d = negRes_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MDU_DIV_EN
    isDiv_d  = isDiv_q;
    negRem_d = negRem_q;
    dz_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (startOk) begin
          count_d  = '0;
          negRes_d = isSigned & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
          state_d  = RUN;
`ifdef MDU_DIV_EN
          isDiv_d  = op[1];
          negRem_d = isSigned & rs_data[XLEN-1];
          if (op[1]) begin
            opA_d = absRt;
            acc_d = {{XLEN{1'b0}}, absRs};
            if (rt_data == '0) state_d = DZ;
          end else begin
            opA_d = absRs;
            acc_d = {{XLEN{1'b0}}, absRt};
          end
`else
          opA_d = absRs;
          acc_d = {{XLEN{1'b0}}, absRt};
`endif
        end else if (!start) begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      RUN: begin
        count_d = count_q + CW'(1);
`ifdef MDU_DIV_EN
        acc_d = isDiv_q ? divNext : mulNext;
`else
        acc_d = mulNext;
`endif
        if (count_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef MDU_DIV_EN
          if (isDiv_q) begin
            hi_d = remFinal;
            lo_d = quotFinal;
          end else begin
            hi_d = mulFinal[2*XLEN-1:XLEN];
            lo_d = mulFinal[XLEN-1:0];
          end
`else
          hi_d = mulFinal[2*XLEN-1:XLEN];
          lo_d = mulFinal[XLEN-1:0];
`endif
        end
      end
`ifdef MDU_DIV_EN
      DZ: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dz_d    = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opA_q    <= '0;
      negRes_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      isDiv_q  <= 1'b0;
      negRem_q <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opA_q    <= opA_d;
      negRes_q <= negRes_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MDU_DIV_EN
      isDiv_q  <= isDiv_d;
      negRem_q <= negRem_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
`ifdef MDU_DIV_EN
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops against a 64-bit arithmetic model.
// Divide cases follow MDU_DIV_EN; without it, divide requests are expected to be ignored.
module tb_mult_div_unit;

`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rsData, rtData;
  logic        mthi, mtlo;
  logic [31:0] hiO, loO;
  logic        busyO, doneO, dzO;

  int checks = 0;
  int errors = 0;
  logic [31:0] hiM = '0;
  logic [31:0] loM = '0;

  mult_div_unit #(.XLEN(32)) dut (
    .Clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rsData), .rt_data(rtData), .mthi(mthi), .mtlo(mtlo),
    .hi(hiO), .lo(loO), .busy(busyO), .done(doneO), .div_by_zero(dzO)
  );

  always #5 clk = ~clk;

  // Hard stop in case the bench itself gets stuck somewhere.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (dzO === 1'b1) checkOutput("dz_only_with_done", {63'b0, doneO}, 64'd1);
  end

  // Architectural result of one operation, computed with plain 64-bit arithmetic.
  function automatic void refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin sp = sa * sb; up = 64'(sp); h = up[63:32]; l = up[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
      2'b10: if (b != 0) begin
               sq = sa / sb; sr = sa % sb;
               up = 64'(sq); l = up[31:0];
               up = 64'(sr); h = up[31:0];
             end
      default: if (b != 0) begin l = a / b; h = a % b; end
    endcase
  endfunction

  // Issues one request at the current negedge and returns in the cycle where done is expected.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b,
                               input int disturbAt, input bit withMtlo);
    bit accepted, isDz;
    int expBusy, cycles;
    accepted = DivEn || !opIn[1];
    isDz     = accepted && opIn[1] && (b == 32'd0);
    expBusy  = !accepted ? 0 : (isDz ? 1 : 32);
    start = 1'b1; op = opIn; rsData = a; rtData = b; mthi = 1'b0; mtlo = withMtlo;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    cycles = 0;
    while (busyO && cycles < 40) begin
      cycles++;
      if (cycles == disturbAt) begin
        start = 1'b1; op = 2'b00; rsData = 32'hDEAD; rtData = 32'h9; mthi = 1'b1; mtlo = 1'b1;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    if (accepted && !isDz) refModel(opIn, a, b, hiM, loM);
    checkOutput("busy_cycles", 64'(cycles), 64'(expBusy));
    checkOutput("done", {63'b0, doneO}, {63'b0, accepted});
    checkOutput("div_by_zero", {63'b0, dzO}, {63'b0, isDz});
    checkOutput("hi", {32'b0, hiO}, {32'b0, hiM});
    checkOutput("lo", {32'b0, loO}, {32'b0, loM});
  endtask

  task automatic idleWrite(input bit wHi, input bit wLo, input logic [31:0] v);
    start = 1'b0; mthi = wHi; mtlo = wLo; rsData = v;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (wHi) hiM = v;
    if (wLo) loM = v;
    checkOutput("mt_hi", {32'b0, hiO}, {32'b0, hiM});
    checkOutput("mt_lo", {32'b0, loO}, {32'b0, loM});
    checkOutput("mt_busy", {63'b0, busyO}, 64'd0);
    checkOutput("mt_done", {63'b0, doneO}, 64'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          doneSeen;

    reset = 1'b1; start = 1'b0; op = 2'b00; rsData = '0; rtData = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_hi", {32'b0, hiO}, 64'd0);
    checkOutput("reset_lo", {32'b0, loO}, 64'd0);
    checkOutput("reset_busy", {63'b0, busyO}, 64'd0);
    checkOutput("reset_done", {63'b0, doneO}, 64'd0);
    checkOutput("reset_dz", {63'b0, dzO}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
    checkOutput("multu_max_hi", {32'b0, hiO}, 64'hFFFFFFFE);
    checkOutput("multu_max_lo", {32'b0, loO}, 64'h00000001);
    @(negedge clk);
    checkOutput("done_single_pulse", {63'b0, doneO}, 64'd0);

    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, -1, 1'b0);
    checkOutput("mult_neg_hi", {32'b0, hiO}, 64'hFFFFFFFF);
    checkOutput("mult_neg_lo", {32'b0, loO}, 64'hFFFFFFF1);
    applyStimulus(2'b00, 32'd7, 32'd6, -1, 1'b0);
    checkOutput("b2b_hi", {32'b0, hiO}, 64'd0);
    checkOutput("b2b_lo", {32'b0, loO}, 64'd42);
    @(negedge clk);

`ifdef MDU_DIV_EN
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
    checkOutput("div_neg_lo", {32'b0, loO}, 64'hFFFFFFFD);
    checkOutput("div_neg_hi", {32'b0, hiO}, 64'hFFFFFFFF);
    @(negedge clk);
    applyStimulus(2'b11, 32'd100, 32'd7, -1, 1'b0);
    checkOutput("divu_lo", {32'b0, loO}, 64'd14);
    checkOutput("divu_hi", {32'b0, hiO}, 64'd2);
    @(negedge clk);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    checkOutput("div_wrap_lo", {32'b0, loO}, 64'h80000000);
    checkOutput("div_wrap_hi", {32'b0, hiO}, 64'd0);
    @(negedge clk);
    idleWrite(1'b1, 1'b0, 32'h11);
    idleWrite(1'b0, 1'b1, 32'h22);
    applyStimulus(2'b11, 32'd5, 32'd0, -1, 1'b0);
    checkOutput("dz_hi_kept", {32'b0, hiO}, 64'h11);
    checkOutput("dz_lo_kept", {32'b0, loO}, 64'h22);
    @(negedge clk);
`else
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
    checkOutput("div_ignored_lo", {32'b0, loO}, 64'd42);
    @(negedge clk);
`endif

    applyStimulus(2'b01, 32'd3, 32'd4, 10, 1'b0);
    checkOutput("ignored_req_hi", {32'b0, hiO}, 64'd0);
    checkOutput("ignored_req_lo", {32'b0, loO}, 64'd12);
    @(negedge clk);

    idleWrite(1'b1, 1'b0, 32'h5A5A);
`ifdef MDU_DIV_EN
    op = 2'b10;
`else
    op = 2'b00;
`endif
    rsData = 32'hFFFFFF9C; rtData = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hiM = '0; loM = '0;
    checkOutput("midop_reset_hi", {32'b0, hiO}, 64'd0);
    checkOutput("midop_reset_lo", {32'b0, loO}, 64'd0);
    checkOutput("midop_reset_busy", {63'b0, busyO}, 64'd0);
    checkOutput("midop_reset_done", {63'b0, doneO}, 64'd0);
    checkOutput("midop_reset_dz", {63'b0, dzO}, 64'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (doneO) doneSeen++;
    end
    checkOutput("no_done_after_reset", 64'(doneSeen), 64'd0);

    idleWrite(1'b1, 1'b0, 32'hAAAA);
    checkOutput("mthi_aaaa", {32'b0, hiO}, 64'hAAAA);
    idleWrite(1'b1, 1'b1, 32'h5555);

    applyStimulus(2'b01, 32'h1234, 32'h10, -1, 1'b1);
    checkOutput("start_beats_mtlo", {32'b0, loO}, 64'h12340);
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pickOperand();
      rb  = pickOperand();
      applyStimulus(rop, ra, rb, -1, 1'b0);
      @(negedge clk);
      checkOutput("rand_done_low", {63'b0, doneO}, 64'd0);
      if ($urandom_range(0, 3) == 0) idleWrite(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS-32 core. It sits downstream of the register file, alongside the 32-bit ALU in the execute stage. It consumes the Rs/Rt read data and executes MULT, MULTU, DIV and DIVU over multiple cycles. The 64-bit result is held in HI/LO for later MFHI/MFLO, and `busy` is the stall request to the control path.

## Interface
- `XLEN`, 32, operand and HI/LO width; only 32 is supported.
- `Clk` input 1: the single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a new operation; sampled only when `busy`=0.
- `op` input 2: operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data` input 32: multiplicand or dividend; also the MTHI/MTLO source.
- `rt_data` input 32: multiplier or divisor.
- `mthi` input 1: write `rs_data` to HI.
- `mtlo` input 1: write `rs_data` to LO.
- `hi` output 32: HI register (product[63:32] or remainder).
- `lo` output 32: LO register (product[31:0] or quotient).
- `busy` output 1: an operation is in progress; the core stalls while it is high.
- `done` output 1: one-cycle pulse when an operation completes.
- `div_by_zero` output 1: valid with `done`; the divide had `rt_data`=0.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: iteration counter 0..31.
  - DZ: divide-by-zero completion.
- IDLE with `start`=1:
  - Latch operands and `op`.
  - For signed ops, store the operand magnitudes and the result-sign flags.
  - Divide with `rt_data`=0 goes to DZ; every other op goes to RUN with count=0.
- RUN, multiply: shift-add, one multiplier bit per cycle, 64-bit partial-product accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, 33-bit remainder path.
- RUN at count=31:
  - Apply the sign correction and write HI/LO.
  - Go to IDLE and pulse `done`.
- Signed multiply: the 64-bit product is negated when the operand signs differ.
- Signed divide:
  - Quotient sign is sign(rs) XOR sign(rt).
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no exception).
- DZ:
  - HI/LO are unchanged.
  - `done`=1 and `div_by_zero`=1 for one cycle, then IDLE.
- MTHI/MTLO:
  - Honoured only in IDLE with `start`=0; the register is written at the next edge.
  - Both may be asserted together.
  - Dropped while `busy`=1 or when `start`=1 in the same cycle (start has priority).
- `start` while `busy`=1 is ignored; no queueing.
- `hi`/`lo` always reflect the registers; mid-operation accumulator values are never visible.

## Timing
- Reset values:
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0.
  - State is IDLE, counter is 0.
- Reset mid-operation aborts at the next edge, with the same values as above.
- Let E0 be the edge that accepts `start`.
- Normal operation:
  - `busy` is high from after E0 through E32; 32 cycles total.
  - HI/LO are updated at E32.
  - `done` is high for the one cycle after E32, and `busy` is low in that same cycle.
- Back-to-back operations: a new `start` is accepted in the `done` cycle, so the issue rate is 33 cycles per operation.
- Divide by zero:
  - `busy` is high for exactly one cycle (E0 to E1).
  - `done`=1 and `div_by_zero`=1 are high in the cycle after E1.
- `div_by_zero` is 0 whenever `done`=0.
- MTHI/MTLO latency is one edge; there is no `busy` and no `done`.
- No combinational path from `start` to `busy`.

## Configuration
- `MDU_DIV_EN` defined: all four ops are supported as above.
- `MDU_DIV_EN` undefined:
  - The divider datapath and the DZ state are not compiled.
  - `start` with `op`=1x is ignored: `busy` stays 0, no `done`, HI/LO unchanged.
  - `div_by_zero` is tied to 0.
  - Multiply behaviour and timing are unchanged.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `busy` high for 32 cycles; HI=0xFFFFFFFE, LO=0x00000001; `done` pulses once.
- MULT −3 × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Back-to-back MULT 7 × 6 issued in the `done` cycle -> HI=0, LO=42 after 32 more cycles.
- DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 5 / 0 with HI/LO preloaded to 0x11/0x22 -> `busy` for one cycle, then `done`=`div_by_zero`=1; HI/LO stay 0x11/0x22.
- Ignored requests during MULTU 3 × 4, cycle 10: `start` with new operands, plus `mthi`/`mtlo` with rs=0xDEAD. All are ignored; result is HI=0, LO=12.
- Reset and idle writes:
  - Assert `reset` at cycle 15 of a DIV -> next cycle all outputs are 0 and no `done` follows.
  - Then MTHI 0xAAAA -> HI=0xAAAA one edge later.
  - Then `start` and `mtlo` in the same cycle -> LO is overwritten by the operation result.
